scr1_dmem_arb2: RTL and testbench

SCR1_DMEM_ARB2 -- requirements
Module: scr1_dmem_arb2

---
 rtl/scr1_dmem_arb2.sv | 169 ++++++++++++++++
 tb/tb_scr1_dmem_arb2.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_dmem_arb2.sv
// Two-requester data-memory arbiter: muxes two address-phase requesters onto
// one shared memory port, keeps at most one transaction outstanding, and
// routes the data-phase response back to the requester that owns it.

package scr1_dmem_arb2_pkg;
    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_arb2
    import scr1_dmem_arb2_pkg::*;
#(
    parameter bit SCR1_ARB_FIXED_PRIO = 1'b0   // 0: round-robin, 1: m0 always wins ties
) (
    input  logic                        clk,
    input  logic                        rst_n,
    // requester 0
    input  logic                        m0_req,
    output logic                        m0_req_ack,
    input  type_scr1_mem_cmd_e          m0_cmd,
    input  type_scr1_mem_width_e        m0_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] m0_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] m0_wdata,
    output logic [SCR1_DMEM_DWIDTH-1:0] m0_rdata,
    output type_scr1_mem_resp_e         m0_resp,
    // requester 1
    input  logic                        m1_req,
    output logic                        m1_req_ack,
    input  type_scr1_mem_cmd_e          m1_cmd,
    input  type_scr1_mem_width_e        m1_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] m1_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] m1_wdata,
    output logic [SCR1_DMEM_DWIDTH-1:0] m1_rdata,
    output type_scr1_mem_resp_e         m1_resp,
    // shared port
    output logic                        s_req,
    input  logic                        s_req_ack,
    output type_scr1_mem_cmd_e          s_cmd,
    output type_scr1_mem_width_e        s_width,
    output logic [SCR1_DMEM_AWIDTH-1:0] s_addr,
    output logic [SCR1_DMEM_DWIDTH-1:0] s_wdata,
    input  logic [SCR1_DMEM_DWIDTH-1:0] s_rdata,
    input  type_scr1_mem_resp_e         s_resp
);

    typedef enum logic {
        PH_ADDR = 1'b0,   // nothing outstanding
        PH_DATA = 1'b1    // one transaction outstanding, owned by owner_q
    } phase_e;

    phase_e state_q, state_d;
    logic   owner_q, owner_d;      // requester owning the outstanding transaction
    logic   last_q, last_d;        // requester granted on the most recent handshake
    logic   lock_q, lock_d;        // a stalled request is holding the port
    logic   lock_id_q, lock_id_d;  // which requester holds the lock

    logic addr_open;
    logic lock_hold;
    logic grant;
    logic handshake;

    // Arbitration: pick the grant and drive the address-phase request/acks.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        addr_open = (state_q == PH_ADDR) || (s_resp == SCR1_MEM_RESP_RDY_OK);
        lock_hold = lock_q & (lock_id_q ? m1_req : m0_req);
        grant     = 1'b0;
        if (lock_hold) begin
            grant = lock_id_q;
        end else if (m0_req ^ m1_req) begin
            grant = m1_req;
        end else if (m0_req & m1_req) begin
            grant = SCR1_ARB_FIXED_PRIO ? 1'b0 : ~last_q;
        end
        // NOTE: the async reset pins the FSM to ADDR, which alone would leave the address phase open, so s_req is gated by rst_n directly.
        s_req      = rst_n & addr_open & (grant ? m1_req : m0_req);
        handshake  = s_req & s_req_ack;
        m0_req_ack = handshake & ~grant;
        m1_req_ack = handshake & grant;
    end

    // Request attributes follow the granted requester (m0 when idle).
    assign s_cmd   = grant ? m1_cmd   : m0_cmd;
    assign s_width = grant ? m1_width : m0_width;
    assign s_addr  = grant ? m1_addr  : m0_addr;
    assign s_wdata = grant ? m1_wdata : m0_wdata;

    // Phase FSM next state plus owner, round-robin history and stall lock.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        lock_d    = lock_hold;   // lock falls away once the locked requester drops req
        lock_id_d = lock_id_q;
        unique case (state_q)
            PH_ADDR: begin
                if (handshake) state_d = PH_DATA;
            end
            PH_DATA: begin
                case (s_resp)
                    SCR1_MEM_RESP_RDY_OK: state_d = handshake ? PH_DATA : PH_ADDR;
                    SCR1_MEM_RESP_RDY_ER: state_d = PH_ADDR;
                    default:              state_d = PH_DATA;
                endcase
            end
        endcase
        if (handshake) begin
            owner_d = grant;
            last_d  = grant;
            lock_d  = 1'b0;
        end else if (s_req) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end
    end

    // State registers; last_q resets to 1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PH_ADDR;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Data-phase return goes only to the owner; everyone else sees NOTRDY.
    always_comb begin
        m0_resp  = SCR1_MEM_RESP_NOTRDY;
        m0_rdata = '0;
        m1_resp  = SCR1_MEM_RESP_NOTRDY;
        m1_rdata = '0;
        if (state_q == PH_DATA) begin
            if (owner_q) begin
                m1_resp  = s_resp;
                m1_rdata = s_rdata;
            end else begin
                m0_resp  = s_resp;
                m0_rdata = s_rdata;
            end
        end
    end

endmodule

// File: tb/tb_scr1_dmem_arb2.sv
// Bench for scr1_dmem_arb2: a round-robin and a fixed-priority instance share
// the same stimulus; a transaction-level model predicts both every cycle.

module tb_scr1_dmem_arb2;
    import scr1_dmem_arb2_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic                        m0_req, m1_req, s_req_ack;
    type_scr1_mem_cmd_e          m0_cmd, m1_cmd;
    type_scr1_mem_width_e        m0_width, m1_width;
    logic [SCR1_DMEM_AWIDTH-1:0] m0_addr, m1_addr;
    logic [SCR1_DMEM_DWIDTH-1:0] m0_wdata, m1_wdata, s_rdata;
    type_scr1_mem_resp_e         s_resp;

    // index 0: round-robin instance, index 1: fixed-priority instance
    logic [1:0]                  s_req_w, m0_ack_w, m1_ack_w;
    type_scr1_mem_cmd_e          s_cmd_w   [2];
    type_scr1_mem_width_e        s_width_w [2];
    logic [SCR1_DMEM_AWIDTH-1:0] s_addr_w  [2];
    logic [SCR1_DMEM_DWIDTH-1:0] s_wdata_w [2];
    logic [SCR1_DMEM_DWIDTH-1:0] m0_rdata_w[2], m1_rdata_w[2];
    type_scr1_mem_resp_e         m0_resp_w [2], m1_resp_w [2];

    scr1_dmem_arb2 #(.SCR1_ARB_FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_req_ack(m0_ack_w[0]), .m0_cmd(m0_cmd), .m0_width(m0_width),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata_w[0]), .m0_resp(m0_resp_w[0]),
        .m1_req(m1_req), .m1_req_ack(m1_ack_w[0]), .m1_cmd(m1_cmd), .m1_width(m1_width),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata_w[0]), .m1_resp(m1_resp_w[0]),
        .s_req(s_req_w[0]), .s_req_ack(s_req_ack), .s_cmd(s_cmd_w[0]), .s_width(s_width_w[0]),
        .s_addr(s_addr_w[0]), .s_wdata(s_wdata_w[0]), .s_rdata(s_rdata), .s_resp(s_resp)
    );

    scr1_dmem_arb2 #(.SCR1_ARB_FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_req_ack(m0_ack_w[1]), .m0_cmd(m0_cmd), .m0_width(m0_width),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata_w[1]), .m0_resp(m0_resp_w[1]),
        .m1_req(m1_req), .m1_req_ack(m1_ack_w[1]), .m1_cmd(m1_cmd), .m1_width(m1_width),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata_w[1]), .m1_resp(m1_resp_w[1]),
        .s_req(s_req_w[1]), .s_req_ack(s_req_ack), .s_cmd(s_cmd_w[1]), .s_width(s_width_w[1]),
        .s_addr(s_addr_w[1]), .s_wdata(s_wdata_w[1]), .s_rdata(s_rdata), .s_resp(s_resp)
    );

    // ---------------- reference model (transaction level) ----------------
    int pend     [2];   // requester whose transaction is outstanding, -1 if none
    int last_win [2];   // requester that won the last handshake
    int stalled  [2];   // requester holding the port after an un-acked request, -1 if none
    int e_g      [2];   // predicted grant this cycle
    bit e_sreq   [2];   // predicted shared request this cycle
    bit have_eval;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic void model_reset();
        for (int p = 0; p < 2; p++) begin
            pend[p]     = -1;
            last_win[p] = 1;
            stalled[p]  = -1;
        end
        have_eval = 1'b0;
    endfunction

    function automatic bit req_of(int who);
        return (who == 1) ? m1_req : m0_req;
    endfunction

    // Who gets the port: a stalled requester keeps it, a lone requester gets it,
    // ties go to m0 (fixed) or to whoever did not win last time (round-robin).
    function automatic int pick(int p);
        if (stalled[p] >= 0 && req_of(stalled[p])) return stalled[p];
        if (m0_req && !m1_req) return 0;
        if (m1_req && !m0_req) return 1;
        if (m0_req && m1_req)  return (p == 1) ? 0 : 1 - last_win[p];
        return 0;
    endfunction

    // Predict this cycle's outputs for both instances and compare.
    task automatic eval_and_compare();
        bit          open_ph, sreq;
        int          g;
        string       nm;
        logic [2:0]  exp_ctl;
        logic [33:0] exp_r0, exp_r1;
        logic [66:0] exp_mux;
        for (int p = 0; p < 2; p++) begin
            nm      = (p == 1) ? "fp" : "rr";
            open_ph = (pend[p] < 0) || (s_resp == SCR1_MEM_RESP_RDY_OK);
            g       = pick(p);
            sreq    = open_ph && req_of(g);
            e_g[p]    = g;
            e_sreq[p] = sreq;
            exp_ctl = {sreq, sreq && s_req_ack && (g == 0), sreq && s_req_ack && (g == 1)};
            exp_r0  = (pend[p] == 0) ? {s_resp, s_rdata} : {SCR1_MEM_RESP_NOTRDY, 32'h0};
            exp_r1  = (pend[p] == 1) ? {s_resp, s_rdata} : {SCR1_MEM_RESP_NOTRDY, 32'h0};
            exp_mux = (g == 1) ? {m1_cmd, m1_width, m1_addr, m1_wdata}
                               : {m0_cmd, m0_width, m0_addr, m0_wdata};
            check({nm, ".ctl"}, {s_req_w[p], m0_ack_w[p], m1_ack_w[p]}, exp_ctl);
            check({nm, ".m0ret"}, {m0_resp_w[p], m0_rdata_w[p]}, exp_r0);
            check({nm, ".m1ret"}, {m1_resp_w[p], m1_rdata_w[p]}, exp_r1);
            check({nm, ".mux"}, {s_cmd_w[p], s_width_w[p], s_addr_w[p], s_wdata_w[p]}, exp_mux);
        end
        have_eval = 1'b1;
    endtask

    // Advance the model across a clock edge using the inputs still applied.
    task automatic commit();
        if (!have_eval) return;
        for (int p = 0; p < 2; p++) begin
            if (pend[p] >= 0 && s_resp != SCR1_MEM_RESP_NOTRDY) pend[p] = -1;
            if (e_sreq[p] && s_req_ack) begin
                pend[p]     = e_g[p];
                last_win[p] = e_g[p];
                stalled[p]  = -1;
            end else if (e_sreq[p]) begin
                stalled[p] = e_g[p];
            end else if (stalled[p] >= 0 && !req_of(stalled[p])) begin
                stalled[p] = -1;
            end
        end
    endtask

    task automatic step(input bit r0, input bit r1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input bit ack, input type_scr1_mem_resp_e rsp, input logic [31:0] rd);
        @(posedge clk);
        commit();
        #1;
        m0_req    = r0;
        m1_req    = r1;
        m0_addr   = a0;
        m1_addr   = a1;
        s_req_ack = ack;
        s_resp    = rsp;
        s_rdata   = rd;
        m0_cmd    = type_scr1_mem_cmd_e'($urandom_range(0, 1));
        m1_cmd    = type_scr1_mem_cmd_e'($urandom_range(0, 1));
        m0_width  = type_scr1_mem_width_e'($urandom_range(0, 2));
        m1_width  = type_scr1_mem_width_e'($urandom_range(0, 2));
        m0_wdata  = $urandom;
        m1_wdata  = $urandom;
        @(negedge clk);
        cyc++;
        eval_and_compare();
    endtask

    // Pulse reset with busy-looking inputs and check the reset-time outputs.
    task automatic reset_pulse();
        rst_n     = 1'b0;
        m0_req    = 1'b1;
        m1_req    = 1'b1;
        s_req_ack = 1'b1;
        s_resp    = SCR1_MEM_RESP_RDY_OK;
        s_rdata   = 32'h1234_5678;
        #1;
        for (int p = 0; p < 2; p++) begin
            check("rst.ctl", {s_req_w[p], m0_ack_w[p], m1_ack_w[p]}, 3'b000);
            check("rst.m0ret", {m0_resp_w[p], m0_rdata_w[p]}, {SCR1_MEM_RESP_NOTRDY, 32'h0});
            check("rst.m1ret", {m1_resp_w[p], m1_rdata_w[p]}, {SCR1_MEM_RESP_NOTRDY, 32'h0});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        m0_req    = 1'b0;
        m1_req    = 1'b0;
        s_req_ack = 1'b0;
        s_resp    = SCR1_MEM_RESP_NOTRDY;
        model_reset();
    endtask

    localparam logic [31:0] A0 = 32'h0000_0A00;
    localparam logic [31:0] A1 = 32'h0000_0B10;

    initial begin
        bit                  r0, r1;
        int                  x;
        type_scr1_mem_resp_e rsp;

        m0_req = 0; m1_req = 0; s_req_ack = 0;
        m0_cmd = SCR1_MEM_CMD_RD; m1_cmd = SCR1_MEM_CMD_RD;
        m0_width = SCR1_MEM_WIDTH_WORD; m1_width = SCR1_MEM_WIDTH_WORD;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        s_resp = SCR1_MEM_RESP_NOTRDY; s_rdata = 0;
        model_reset();
        #2;
        reset_pulse();

        // single requester: ack in cycle 0, data back in cycle 1
        step(1, 0, 32'h100, A1, 1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        check("single.ack", {m0_ack_w[0], m1_ack_w[0]}, 2'b10);
        check("single.addr", s_addr_w[0], 32'h100);
        step(0, 0, A0, A1, 0, SCR1_MEM_RESP_RDY_OK, 32'hDEAD_BEEF);
        check("single.m0ret", {m0_resp_w[0], m0_rdata_w[0]}, {SCR1_MEM_RESP_RDY_OK, 32'hDEAD_BEEF});
        check("single.m1ret", {m1_resp_w[0], m1_rdata_w[0]}, {SCR1_MEM_RESP_NOTRDY, 32'h0});
        step(0, 0, A0, A1, 0, SCR1_MEM_RESP_NOTRDY, 32'h0);

        // ties with an always-ready slave: rr alternates, fp always picks m0
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, A0, A1, 1, SCR1_MEM_RESP_RDY_OK, $urandom);
            check("tie.rr", {s_req_w[0], m0_ack_w[0], m1_ack_w[0]},
                  {1'b1, (i % 2) == 0, (i % 2) == 1});
            check("tie.fp", {s_req_w[1], m0_ack_w[1], m1_ack_w[1]}, 3'b110);
        end
        step(0, 0, A0, A1, 0, SCR1_MEM_RESP_RDY_OK, 32'h5555_0000);

        // stall lock: m1 un-acked for 3 cycles, m0 arrives in cycle 1
        for (int i = 0; i < 4; i++) begin
            step(i >= 1, 1, A0, A1, i == 3, SCR1_MEM_RESP_NOTRDY, 32'h0);
            check("lock.addr.rr", s_addr_w[0], A1);
            check("lock.addr.fp", s_addr_w[1], A1);
        end
        check("lock.ack", {m0_ack_w[0], m1_ack_w[0], m0_ack_w[1], m1_ack_w[1]}, 4'b0101);
        step(1, 1, A0, A1, 1, SCR1_MEM_RESP_RDY_OK, 32'h1111_2222);
        check("lock.next.rr", {s_req_w[0], m0_ack_w[0], m1_ack_w[0]}, 3'b110);
        check("lock.next.fp", {s_req_w[1], m0_ack_w[1], m1_ack_w[1]}, 3'b110);

        // error response to m0 while m1 waits
        step(0, 1, A0, A1, 1, SCR1_MEM_RESP_RDY_ER, 32'hBAD0_0BAD);
        check("err.sreq", s_req_w, 2'b00);
        check("err.m0ret", {m0_resp_w[0], m0_rdata_w[0]}, {SCR1_MEM_RESP_RDY_ER, 32'hBAD0_0BAD});
        step(0, 1, A0, A1, 1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        check("err.next", {m1_ack_w, s_addr_w[0]}, {2'b11, A1});

        // reset while m1's transaction is outstanding: it is discarded
        reset_pulse();
        step(0, 0, A0, A1, 0, SCR1_MEM_RESP_RDY_OK, 32'hCAFE_F00D);
        check("rst.discard", {m1_resp_w[0], m1_rdata_w[0], m1_resp_w[1], m1_rdata_w[1]},
              {SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_NOTRDY, 32'h0});

        // randomized traffic with occasional resets
        r0 = 0;
        r1 = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r0 = ~r0;
            if ($urandom_range(0, 3) == 0) r1 = ~r1;
            x   = $urandom_range(0, 19);
            rsp = (x < 6) ? SCR1_MEM_RESP_NOTRDY :
                  (x < 17) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
            step(r0, r1, $urandom, $urandom, $urandom_range(0, 9) < 7, rsp, $urandom);
            if (i % 200 == 199) reset_pulse();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
